regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-read-port general-purpose register file for the CPU datapath.
//   Next generation of the 32x32 two-read-port file, with these additions:
//   configurable width, depth and read-port count; a write-ready handshake;
//   a sequenced bulk-clear engine; and an optional same-cycle write-to-read bypass.
//   Sits between decode (read addresses) and writeback (write port). The debug port feeds the test harness.
// PARAMETERS
//   DW        32  data width in bits
//   DEPTH     32  number of entries; power of two, >= 2
//   NRD       2   number of read ports, 1..4
//   ZERO_REG  1   1: entry 0 is hardwired to zero, and writes to it are discarded
//   AW        $clog2(DEPTH)  address width; derived, do not override
// PORTS
//   clk        in   1        clock; all state changes on the rising edge
//   resetn     in   1        asynchronous active-low reset
//   wen        in   1        write request
//   waddr      in   AW       write address
//   wdata      in   DW       write data
//   wr_ready   out  1        write port can accept; 0 while a clear is in progress
//   raddr      in   NRD*AW   read addresses, packed; port i = [i*AW +: AW]
//   rdata      out  NRD*DW   read data, packed; port i = [i*DW +: DW]
//   test_addr  in   AW       debug read address
//   test_data  out  DW       debug read data; never bypassed
//   clr_req    in   1        request to zero every entry
//   clr_busy   out  1        clear sequence in progress
//   clr_done   out  1        one-cycle pulse when the clear sequence completes
// BEHAVIOUR
//   - Reset (resetn=0, asynchronous):
//     - all entries = 0; FSM = IDLE; clr_ptr = 0.
//     - clr_busy = 0, clr_done = 0, wr_ready = 1.
//     - Reset asserted mid-clear aborts the sequence immediately.
//   - FSM states: IDLE, CLEAR.
//     - IDLE -> CLEAR when clr_req=1; clr_ptr <= 0.
//     - In CLEAR, each cycle: rf[clr_ptr] <= 0; clr_ptr <= clr_ptr+1.
//     - CLEAR -> IDLE on the cycle clr_ptr == DEPTH-1; clr_done = 1 in the following cycle only.
//     - clr_busy = (state == CLEAR). Busy lasts exactly DEPTH cycles.
//     - clr_req while in CLEAR is ignored; it does not restart the sequence.
//     - clr_req held high continuously starts a new sequence on the first cycle back in IDLE.
//   - Write handshake:
//     - wr_ready = !clr_busy; a write is accepted when wen && wr_ready.
//     - An accepted write updates rf[waddr] at the clock edge.
//     - wen while wr_ready=0 is dropped. The source must hold the request; no queueing.
//     - ZERO_REG=1 and waddr=0: the write is accepted but has no effect.
//     - clr_req and wen in the same IDLE cycle: the write commits, then CLEAR begins next cycle and erases it.
//   - Reads (combinational, zero latency):
//     - rdata[i] = rf[raddr[i]].
//     - Returns 0 for ZERO_REG=1 with address 0.
//     - During CLEAR, entries not yet cleared still return their old values.
//   - Widths: no arithmetic on data; clr_ptr is AW bits and wraps naturally.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - For each read port i, if the write is accepted this cycle and raddr[i]==waddr
//       (excluding address 0 when ZERO_REG=1), then rdata[i] = wdata in the same cycle.
//   REGFILE_BYPASS_EN undefined:
//     - rdata reflects the array contents only; a write becomes visible the cycle after its edge.
//   test_data is unaffected in both configurations.
// STRUCTURE
//   Package regfile_pkg:
//     - rf_state_e enum {RF_IDLE, RF_CLEAR}
//     - localparam defaults RF_DW=32, RF_DEPTH=32
//   Sub-module regfile_rd_mux (DW, DEPTH, ZERO_REG):
//     - one read port, zero-forcing and optional bypass
//     - instantiated NRD times via generate, plus once for the test port with bypass tied off
//   Storage array, FSM and clear pointer live in the top module.
// TESTING
//   1. Reset, then write 0xDEADBEEF to addr 5
//      -> next cycle: raddr0=5 gives 0xDEADBEEF; test_addr=5 gives the same.
//   2. Write 0x1234 to addr 0 with ZERO_REG=1
//      -> rdata for addr 0 stays 0.
//   3. Fill all 32 entries, then pulse clr_req
//      -> clr_busy high for exactly 32 cycles; clr_done pulses once; every entry then reads 0.
//   4. wen=1 to addr 3 during CLEAR
//      -> wr_ready=0; after the clear, addr 3 reads 0.
//   5. Bypass build: write 0xA5A5A5A5 to addr 7 with raddr1=7 in the same cycle
//      -> rdata1 = 0xA5A5A5A5 that cycle, while test_data(7) shows the old value.
//      Non-bypass build: same stimulus -> rdata1 shows the old value.
//   6. Deassert resetn mid-clear at ptr=10
//      -> all entries 0, clr_busy 0 immediately, no clr_done pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

endpackage

// File: rtl/regfile_if.sv
// Write and read-port bundle between the datapath and the register file.
// The master side (decode/writeback) drives addresses and write data;
// the slave side (the register file) returns read data and wr_ready.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DW  = RF_DW,
  parameter int AW  = $clog2(RF_DEPTH),
  parameter int NRD = 2
);

  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              wr_ready;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;

  modport master (
    output wen, waddr, wdata, raddr,
    input  wr_ready, rdata
  );

  modport slave (
    input  wen, waddr, wdata, raddr,
    output wr_ready, rdata
  );

endinterface

// File: rtl/regfile_rd_mux.sv
// One combinational read port: array lookup, optional same-cycle write
// bypass, and zero-forcing of entry 0 when it is hardwired.
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic [DW-1:0]              rf [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic                       byp_vld,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata
);

  // Zero-forcing is applied last so a write to entry 0 is never bypassed
  always_comb begin
    rdata = rf[raddr];
    if (byp_vld && (raddr == waddr)) begin
      rdata = wdata;
    end
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-ready handshake
// and a sequenced bulk-clear engine (one entry per cycle, DEPTH cycles).
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write
// to any read port addressing the same entry in the same cycle. The debug
// port (test_addr/test_data) always reads the array contents.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  regfile_if.slave      rf_bus,
  input  logic [AW-1:0] test_addr,
  output logic [DW-1:0] test_data,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  rf_state_e         state_q;
  rf_state_e         state_d;
  logic [AW-1:0]     clr_ptr_q;
  logic [AW-1:0]     clr_ptr_d;
  logic              clr_done_q;
  logic              clr_done_d;
  logic              wr_acc;
  logic              wr_commit;
  logic              byp_vld;
  logic [DW-1:0]     rf [DEPTH];
  logic [NRD*DW-1:0] rdata_all;

  // Clear sequencer: next state, pointer advance and completion pulse
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    clr_busy   = (state_q == RF_CLEAR);
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d   = RF_CLEAR;
          clr_ptr_d = '0;
        end
      end
      RF_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d    = RF_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Sequencer state; reset aborts any clear in progress
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RF_IDLE;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_done        = clr_done_q;
  assign rf_bus.wr_ready = !clr_busy;
  assign wr_acc          = rf_bus.wen && rf_bus.wr_ready;
  // Writes to a hardwired entry 0 are accepted but leave the array alone
  assign wr_commit       = wr_acc && !((ZERO_REG != 0) && (rf_bus.waddr == '0));

`ifdef REGFILE_BYPASS_EN
  assign byp_vld = wr_acc;
`else
  assign byp_vld = 1'b0;
`endif

  // Storage: clearing owns the array while busy, otherwise the write port does
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (state_q == RF_CLEAR) begin
      rf[clr_ptr_q] <= '0;
    end else if (wr_commit) begin
      rf[rf_bus.waddr] <= rf_bus.wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_mux #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rf      (rf),
      .raddr   (rf_bus.raddr[i*AW +: AW]),
      .byp_vld (byp_vld),
      .waddr   (rf_bus.waddr),
      .wdata   (rf_bus.wdata),
      .rdata   (rdata_all[i*DW +: DW])
    );
  end

  assign rf_bus.rdata = rdata_all;

  regfile_rd_mux #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_test_rd (
    .rf      (rf),
    .raddr   (test_addr),
    .byp_vld (1'b0),
    .waddr   (rf_bus.waddr),
    .wdata   (rf_bus.wdata),
    .rdata   (test_data)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DW=32, DEPTH=32, NRD=2, ZERO_REG=1).
// Reference model: a plain array of expected contents plus the spec's read rules.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] test_addr;
  logic [DW-1:0] test_data;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  int vectors = 0;
  int errs    = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  regfile_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

  regfile_mp #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rf_bus    (bus.slave),
    .test_addr (test_addr),
    .test_data (test_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] w1(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Idle-state write: one cycle, model updated by the spec's write rule
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    bus.wen = 1'b0;
    if (a != '0) ref_mem[a] = d;
  endtask

  // Expected read-port value while idle (write port is ready)
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && (a == bus.waddr)) return bus.wdata;
`endif
    return ref_mem[a];
  endfunction

  initial begin
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] old31;
    int busy_n, done_n, done_at, waited, nz;

    bus.wen   = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr = '0;
    test_addr = '0;
    clr_req   = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    #2;
    bus.raddr = {5'd9, 5'd5};
    test_addr = 5'd17;
    #1;
    chk("rst_busy", w1(clr_busy), 32'd0);
    chk("rst_done", w1(clr_done), 32'd0);
    chk("rst_wr_ready", w1(bus.wr_ready), 32'd1);
    chk("rst_rd0", bus.rdata[DW-1:0], 32'd0);
    chk("rst_rd1", bus.rdata[2*DW-1:DW], 32'd0);
    chk("rst_test", test_data, 32'd0);
    #9;
    resetn = 1'b1;
    tick();

    // Basic write / read-back through port 0 and the debug port
    wr(5'd5, 32'hDEADBEEF);
    bus.raddr = {5'd1, 5'd5};
    test_addr = 5'd5;
    #1;
    chk("t1_rd0", bus.rdata[DW-1:0], 32'hDEADBEEF);
    chk("t1_test", test_data, 32'hDEADBEEF);

    // Hardwired entry 0
    wr(5'd0, 32'h00001234);
    bus.raddr = {5'd0, 5'd0};
    test_addr = 5'd0;
    #1;
    chk("t2_rd0", bus.rdata[DW-1:0], 32'd0);
    chk("t2_rd1", bus.rdata[2*DW-1:DW], 32'd0);
    chk("t2_test", test_data, 32'd0);
    tick();

    // Randomised writes and reads against the model
    for (int n = 0; n < 64; n++) begin
      bus.wen   = 1'($urandom_range(0, 1));
      bus.waddr = AW'($urandom_range(0, DEPTH - 1));
      bus.wdata = $urandom;
      a0 = AW'($urandom_range(0, DEPTH - 1));
      a1 = (n % 3 == 0) ? bus.waddr : AW'($urandom_range(0, DEPTH - 1));
      bus.raddr = {a1, a0};
      test_addr = (n % 4 == 0) ? bus.waddr : AW'($urandom_range(0, DEPTH - 1));
      #1;
      chk("rnd_rd0", bus.rdata[DW-1:0], exp_rd(a0));
      chk("rnd_rd1", bus.rdata[2*DW-1:DW], exp_rd(a1));
      chk("rnd_test", test_data, (test_addr == '0) ? 32'd0 : ref_mem[test_addr]);
      chk("rnd_wr_ready", w1(bus.wr_ready), 32'd1);
      @(posedge clk);
      if (bus.wen && (bus.waddr != '0)) ref_mem[bus.waddr] = bus.wdata;
      #2;
    end
    bus.wen = 1'b0;

    // Fill every entry, then run a clear; write attempt to addr 3 mid-clear
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom | 32'h1);
    old31 = ref_mem[31];
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int w = 0; w < 40; w++) begin
      if (clr_busy) busy_n++;
      if (clr_done) begin
        done_n++;
        done_at = w;
      end
      if (w == 5) begin
        bus.wen   = 1'b1;
        bus.waddr = 5'd3;
        bus.wdata = 32'hCAFEF00D;
        bus.raddr = {5'd4, 5'd31};
        #1;
        chk("clr_wr_ready", w1(bus.wr_ready), 32'd0);
        chk("clr_uncleared31", bus.rdata[DW-1:0], old31);
        chk("clr_cleared4", bus.rdata[2*DW-1:DW], 32'd0);
        tick();
      end else begin
        bus.wen = 1'b0;
        tick();
      end
    end
    bus.wen = 1'b0;
    chk("clr_busy_len", 32'(busy_n), 32'd32);
    chk("clr_done_cnt", 32'(done_n), 32'd1);
    chk("clr_done_at", 32'(done_at), 32'd32);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      test_addr = AW'(i);
      bus.raddr = {AW'(i), AW'(i)};
      #1;
      if (test_data != '0) nz++;
      if (bus.rdata[DW-1:0] != '0) nz++;
    end
    chk("clr_all_zero", 32'(nz), 32'd0);
    bus.raddr = {5'd3, 5'd0};
    #1;
    chk("clr_addr3", bus.rdata[2*DW-1:DW], 32'd0);
    tick();

    // clr_req held high: ignored while busy, restarts right after completion
    clr_req = 1'b1;
    tick();
    chk("hold_busy0", w1(clr_busy), 32'd1);
    busy_n = 0;
    waited = 0;
    while (clr_busy && waited < 64) begin
      busy_n++;
      waited++;
      tick();
    end
    chk("hold_len", 32'(busy_n), 32'd32);
    chk("hold_done", w1(clr_done), 32'd1);
    chk("hold_ready_gap", w1(bus.wr_ready), 32'd1);
    tick();
    chk("hold_restart", w1(clr_busy), 32'd1);
    clr_req = 1'b0;
    waited = 0;
    while (clr_busy && waited < 64) begin
      waited++;
      tick();
    end
    chk("hold_end", w1(clr_busy), 32'd0);
    tick();

    // Same-cycle write and read of addr 7
    wr(5'd7, 32'h11111111);
    bus.wen   = 1'b1;
    bus.waddr = 5'd7;
    bus.wdata = 32'hA5A5A5A5;
    bus.raddr = {5'd7, 5'd0};
    test_addr = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t5_rd1_same", bus.rdata[2*DW-1:DW], 32'hA5A5A5A5);
`else
    chk("t5_rd1_same", bus.rdata[2*DW-1:DW], 32'h11111111);
`endif
    chk("t5_test_same", test_data, 32'h11111111);
    tick();
    bus.wen = 1'b0;
    ref_mem[7] = 32'hA5A5A5A5;
    chk("t5_rd1_next", bus.rdata[2*DW-1:DW], 32'hA5A5A5A5);
    chk("t5_test_next", test_data, 32'hA5A5A5A5);

    // Reset asserted mid-clear with the pointer at 10
    wr(5'd20, 32'h0BADF00D);
    wr(5'd31, 32'h600DF00D);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("abort_pre_busy", w1(clr_busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_busy", w1(clr_busy), 32'd0);
    chk("abort_done", w1(clr_done), 32'd0);
    chk("abort_wr_ready", w1(bus.wr_ready), 32'd1);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      test_addr = AW'(i);
      #1;
      if (test_data != '0) nz++;
    end
    chk("abort_all_zero", 32'(nz), 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    tick();
    resetn = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int w = 0; w < 40; w++) begin
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      tick();
    end
    chk("abort_no_busy", 32'(busy_n), 32'd0);
    chk("abort_no_done", 32'(done_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
